// File: rtl/arbiter_rr_stream_pkg.sv
// Shared types for the round-robin stream arbiter: lock FSM states and the grant index width helper.
package arbiter_pkg;

  typedef enum logic {ARB, LOCK} arb_state_t;

  function automatic int id_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arbiter_rr_stream_if.sv
// Stream bundle between N requesters, the arbiter and the single shared consumer.
interface arbiter_rr_stream_if #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32
);
  import arbiter_pkg::*;
  localparam int ID_WIDTH = id_width(N);

  logic [N-1:0]            in_valid;
  logic [N-1:0]            in_ready;
  logic [N*DATA_WIDTH-1:0] in_data;
  logic [N-1:0]            in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_WIDTH-1:0]   out_data;
  logic                    out_last;
  logic [ID_WIDTH-1:0]     out_id;

  // arbiter side
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_id
  );

  // requesters + consumer side
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_id
  );
endinterface

// File: rtl/arbiter_rr_stream_pick.sv
// Combinational round-robin pick: first requester above ptr, else the lowest requester overall.
module rr_pick
  import arbiter_pkg::*;
#(
  parameter int N        = 8,
  parameter int ID_WIDTH = 3
) (
  input  logic [N-1:0]        req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [N-1:0]        grant,
  output logic [ID_WIDTH-1:0] id
);
  logic [N-1:0] masked;
  logic [N-1:0] sel;

  always_comb begin
    masked = '0;
    for (int i = 0; i < N; i++) masked[i] = req[i] && (i > int'(ptr));
    sel = (|masked) ? masked : req;
    id  = '0;
    // downward scan leaves the lowest set bit in id
    for (int i = N - 1; i >= 0; i--) if (sel[i]) id = ID_WIDTH'(i);
    grant = (|sel) ? (N'(1) << id) : '0;
  end
endmodule

// File: rtl/arbiter_rr_stream.sv
// N-to-1 round-robin stream arbiter with a registered output stage.
// Define ARBITER_RR_PACKET_LOCK_EN to hold the grant from first beat to in_last.
module arbiter_rr_stream
  import arbiter_pkg::*;
#(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32
) (
  input logic                clk,
  input logic                rst,
  arbiter_rr_stream_if.slave bus
);
  localparam int ID_WIDTH = id_width(N);

  logic [N-1:0][DATA_WIDTH-1:0] lane_data;
  logic [N-1:0]                 pick_grant, grant, ready;
  logic [ID_WIDTH-1:0]          pick_id, w, ptr;
  logic                         load_en, xfer, last_w;

  logic                  out_valid_q, out_last_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [ID_WIDTH-1:0]   out_id_q;

  for (genvar g = 0; g < N; g++) begin : g_lane
    assign lane_data[g] = bus.in_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_pick #(.N(N), .ID_WIDTH(ID_WIDTH)) u_pick (
    .req  (bus.in_valid),
    .ptr  (ptr),
    .grant(pick_grant),
    .id   (pick_id)
  );

`ifdef ARBITER_RR_PACKET_LOCK_EN
  arb_state_t          state;
  logic [ID_WIDTH-1:0] lock_id;

  // a locked channel that drops valid stalls everyone rather than yielding
  always_comb begin
    if (state == LOCK) begin
      w     = lock_id;
      grant = (N'(1) << lock_id) & bus.in_valid;
    end else begin
      w     = pick_id;
      grant = pick_grant;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ARB;
      lock_id <= '0;
    end else if (xfer) begin
      if (last_w) state <= ARB;
      else begin
        state   <= LOCK;
        lock_id <= w;
      end
    end
  end
`else
  assign w     = pick_id;
  assign grant = pick_grant;
`endif

  assign load_en = !out_valid_q || bus.out_ready;
  assign ready   = (rst || !load_en) ? '0 : grant;
  assign xfer    = |ready;
  assign last_w  = bus.in_last[w];

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_id_q    <= '0;
      ptr         <= ID_WIDTH'(N - 1);
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= lane_data[w];
      out_last_q  <= last_w;
      out_id_q    <= w;
`ifdef ARBITER_RR_PACKET_LOCK_EN
      if (last_w) ptr <= w;
`else
      ptr <= w;
`endif
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_id    = out_id_q;
endmodule

// File: tb/tb_arbiter_rr_stream.sv
// Randomized + directed bench for arbiter_rr_stream against a search-order reference model.
module tb_arbiter_rr_stream;
  import arbiter_pkg::*;
  localparam int N  = 8;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  arbiter_rr_stream_if #(.N(N), .DATA_WIDTH(DW)) bus ();
  arbiter_rr_stream #(.N(N), .DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // reference model: held output beat, last served channel, packet lock
  bit          m_valid;
  logic [DW-1:0] m_data;
  bit          m_last;
  int          m_id, m_ptr;
  bit          m_lock;
  int          m_lock_ch;

  function automatic int winner();
    if (m_lock) return bus.in_valid[m_lock_ch] ? m_lock_ch : -1;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (bus.in_valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic cycle();
    int w;
    logic [N-1:0] er;
    #1;
    w  = winner();
    er = '0;
    if (!rst && (!m_valid || bus.out_ready) && w >= 0) er[w] = 1'b1;
    chk("in_ready", bus.in_ready, er);
    if (rst) begin
      m_valid = 0; m_data = '0; m_last = 0; m_id = 0; m_ptr = N - 1; m_lock = 0; m_lock_ch = 0;
    end else if (er != 0) begin
      m_valid = 1;
      m_data  = bus.in_data[w*DW +: DW];
      m_last  = bus.in_last[w];
      m_id    = w;
`ifdef ARBITER_RR_PACKET_LOCK_EN
      if (!m_last) begin m_lock = 1; m_lock_ch = w; end
      else begin m_lock = 0; m_ptr = w; end
`else
      m_ptr = w;
`endif
    end else if (m_valid && bus.out_ready) begin
      m_valid = 0;
    end
    @(posedge clk);
    @(negedge clk);
    chk("out_valid", bus.out_valid, m_valid);
    chk("out_data",  bus.out_data,  m_data);
    chk("out_last",  bus.out_last,  m_last);
    chk("out_id",    bus.out_id,    m_id);
  endtask

  task automatic rand_data();
    for (int c = 0; c < N; c++) bus.in_data[c*DW +: DW] = $urandom;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lock_exp [4];
`ifdef ARBITER_RR_PACKET_LOCK_EN
    lock_exp = '{1, 1, 1, 0};
`else
    lock_exp = '{1, 0, 1, 0};
`endif
    rst = 1'b1;
    bus.in_valid  = '0;
    bus.in_last   = '1;
    bus.out_ready = 1'b1;
    rand_data();
    cycle();
    bus.in_valid = '1;
    #1 chk("rst_in_ready", bus.in_ready, '0);
    cycle();

    // all channels valid: strict rotation starting at 0
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      rand_data();
      cycle();
      chk("rr_seq", bus.out_id, i % N);
    end

    // single channel beat then backpressure hold
    bus.in_valid = '0;
    cycle();
    bus.in_valid = 8'h08;
    bus.in_data[3*DW +: DW] = 32'hA5A5A5A5;
    bus.out_ready = 1'b0;
    cycle();
    chk("single_id", bus.out_id, 3);
    chk("single_valid", bus.out_valid, 1);
    for (int i = 0; i < 4; i++) begin
      bus.in_data[3*DW +: DW] = $urandom;
      #1 chk("stall_ready", bus.in_ready, '0);
      cycle();
      chk("stall_data", bus.out_data, 32'hA5A5A5A5);
      chk("stall_valid", bus.out_valid, 1);
    end
    bus.out_ready = 1'b1;
    bus.in_data[3*DW +: DW] = 32'h12345678;
    cycle();
    chk("resume_data", bus.out_data, 32'h12345678);

    // reset while a beat is held
    bus.out_ready = 1'b0;
    bus.in_valid  = '1;
    cycle();
    rst = 1'b1;
    cycle();
    chk("rst_drop", bus.out_valid, 0);
    rst = 1'b0;
    bus.in_valid  = 8'h24;
    bus.out_ready = 1'b1;
    #1 chk("rst_first", bus.in_ready, 8'h04);
    cycle();
    chk("rst_first_id", bus.out_id, 2);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("alt_2_5", bus.out_id, (i % 2 == 0) ? 5 : 2);
    end

    // packet lock: ch1 sends 3 beats while ch0 stays valid
    bus.in_valid = 8'h01;
    bus.in_last  = '1;
    cycle();
    bus.in_valid = 8'h03;
    for (int b = 0; b < 4; b++) begin
      bus.in_last[1] = (b == 2);
      rand_data();
      cycle();
      chk("lock_seq", bus.out_id, lock_exp[b]);
    end
    bus.in_last = '1;

    // randomized traffic with backpressure and random packet ends
    for (int i = 0; i < 500; i++) begin
      case ($urandom_range(0, 3))
        0: bus.in_valid = N'($urandom) & N'($urandom);
        1: bus.in_valid = '1;
        default: bus.in_valid = N'($urandom);
      endcase
      bus.in_last   = N'($urandom) | N'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      rand_data();
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
